datamem_ctrl: RTL

Data-memory controller sitting directly downstream of the cache in periphsyswrapper. Accepts one 72-bit line request at a time from the cache's memory-side port and sequences it as two 36-bit beats on the synchronous data SRAM, with a programmable number of wait states per beat. Returns read lines with a valid flag in bit 72 and signals completion of every transaction to the cache.

---
 rtl/datamem_ctrl_if.sv | 29 ++
 rtl/datamem_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/datamem_ctrl_if.sv
// Cache-side request/response bus and SRAM-side word bus of the data-memory controller.
// The controller uses the slave modport; the cache/SRAM side uses the master modport.
interface datamem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 36
);
  logic                  CacheReq;
  logic                  CacheRW;
  logic [ADDR_W-1:0]     CacheAddr;
  logic [2*WORD_W-1:0]   CacheWrData;
  logic                  MemReady;
  logic                  MemAck;
  logic [2*WORD_W:0]     MemRdData;
  logic [ADDR_W-1:0]     SramAddr;
  logic                  SramCe;
  logic                  SramWe;
  logic [WORD_W-1:0]     SramWrData;
  logic [WORD_W-1:0]     SramRdData;

  modport slave (
    input  CacheReq, CacheRW, CacheAddr, CacheWrData, SramRdData,
    output MemReady, MemAck, MemRdData, SramAddr, SramCe, SramWe, SramWrData
  );

  modport master (
    output CacheReq, CacheRW, CacheAddr, CacheWrData, SramRdData,
    input  MemReady, MemAck, MemRdData, SramAddr, SramCe, SramWe, SramWrData
  );
endinterface

// File: rtl/datamem_ctrl.sv
// Data-memory controller: splits one 72-bit cache line request into two 36-bit
// SRAM beats, each held for WAIT_STATES+1 cycles, then acknowledges the cache.
module datamem_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 36
) (
  input  logic            clk,
  input  logic            rst,
  datamem_ctrl_if.slave   bus
);

  localparam int         LINE_W = 2 * WORD_W;
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_cnt;
  logic [3:0]          w_nextCnt;
  logic                w_accept;
  logic                w_beatEnd;
  logic                w_unusedAddrLsb;

  logic                r_rw;
  logic [WORD_W-1:0]   r_wrHi;
  logic [WORD_W-1:0]   r_word0;
  logic [LINE_W-1:0]   r_line;
  logic [ADDR_W-1:0]   r_sramAddr;
  logic [WORD_W-1:0]   r_sramWrData;

  // The line address is word-pair aligned, so the low bit never reaches the SRAM.
  assign w_unusedAddrLsb = bus.CacheAddr[0];

  assign w_accept  = (r_state == IDLE) && bus.CacheReq;
  assign w_beatEnd = (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.CacheReq) begin
          w_nextState = BEAT0;
          w_nextCnt   = WS;
        end
      end
      BEAT0: begin
        if (!w_beatEnd) begin
          w_nextCnt = r_cnt - 4'd1;
        end else begin
          w_nextState = BEAT1;
          w_nextCnt   = WS;
        end
      end
      BEAT1: begin
        if (!w_beatEnd) begin
          w_nextCnt = r_cnt - 4'd1;
        end else begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase
  end

  // Word 0 is parked in r_word0 so the visible read line only changes as a whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw         <= 1'b0;
      r_wrHi       <= '0;
      r_word0      <= '0;
      r_line       <= '0;
      r_sramAddr   <= '0;
      r_sramWrData <= '0;
    end else begin
      if (w_accept) begin
        r_rw         <= bus.CacheRW;
        r_wrHi       <= bus.CacheWrData[LINE_W-1:WORD_W];
        r_sramAddr   <= {bus.CacheAddr[ADDR_W-1:1], 1'b0};
        r_sramWrData <= bus.CacheWrData[WORD_W-1:0];
      end
      if ((r_state == BEAT0) && w_beatEnd) begin
        if (r_rw) begin
          r_word0 <= bus.SramRdData;
        end
        r_sramAddr[0] <= 1'b1;
        r_sramWrData  <= r_wrHi;
      end
      if ((r_state == BEAT1) && w_beatEnd && r_rw) begin
        r_line <= {bus.SramRdData, r_word0};
      end
    end
  end

  assign bus.MemReady   = (r_state == IDLE);
  assign bus.MemAck     = (r_state == DONE);
  assign bus.MemRdData  = {(r_state == DONE) && r_rw, r_line};
  assign bus.SramCe     = (r_state == BEAT0) || (r_state == BEAT1);
  assign bus.SramWe     = ((r_state == BEAT0) || (r_state == BEAT1)) && !r_rw;
  assign bus.SramAddr   = r_sramAddr;
  assign bus.SramWrData = r_sramWrData;

  readyAckExclusive : assert property (@(posedge clk) disable iff (rst)
    !(bus.MemReady && bus.MemAck));

endmodule
